// File: rtl/fmc_adc_lvds_stim_gen_pkg.sv
// rtl/fmc_adc_lvds_stim_gen_pkg.sv - shared types and defaults for the LVDS ADC stimulus generator
package fmc_adc_stim_pkg;

  // Pattern select, encoded exactly as driven on mode_i
  typedef enum logic [1:0] {
    MODE_CONST = 2'd0,
    MODE_RAMP  = 2'd1,
    MODE_TRI   = 2'd2,
    MODE_COUNT = 2'd3
  } mode_e;

  // Triangle sweep direction
  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  localparam int C_NB_CHANNELS  = 4;
  localparam int C_SAMPLE_WIDTH = 14;
  localparam int C_FRAME_BITS   = 8;

endpackage

// File: rtl/fmc_adc_lvds_stim_gen_if.sv
// rtl/fmc_adc_lvds_stim_gen_if.sv - per-channel load/shift link between generator and lane serializer
interface fmc_adc_lane_if
  import fmc_adc_stim_pkg::*;
#(
  parameter int g_SAMPLE_WIDTH = C_SAMPLE_WIDTH
);
  logic                      load;
  logic                      shift;
  logic [g_SAMPLE_WIDTH-1:0] data;
  logic                      a;
  logic                      b;

  modport master (output load, output shift, output data, input a, input b);
  modport slave  (input load, input shift, input data, output a, output b);
endinterface

// File: rtl/fmc_adc_lvds_lane_ser.sv
// rtl/fmc_adc_lvds_lane_ser.sv - parallel-load serializer emitting two bits per clock, MSB pair first
module fmc_adc_lvds_lane_ser
  import fmc_adc_stim_pkg::*;
#(
  parameter int g_SAMPLE_WIDTH = C_SAMPLE_WIDTH
) (
  input  logic           clk_i,
  input  logic           rst_n_i,
  fmc_adc_lane_if.slave  lif
);
  localparam int W = g_SAMPLE_WIDTH;

  logic [W-1:0] sh_q;
  logic         a_q;
  logic         b_q;

  // Load presents the top bit pair immediately; shifting zero-fills so trailing slots go quiet
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      sh_q <= '0;
      a_q  <= 1'b0;
      b_q  <= 1'b0;
    end else if (lif.load) begin
      a_q  <= lif.data[W-1];
      b_q  <= lif.data[W-2];
      sh_q <= lif.data << 2;
    end else if (lif.shift) begin
      a_q  <= sh_q[W-1];
      b_q  <= sh_q[W-2];
      sh_q <= sh_q << 2;
    end else begin
      a_q  <= 1'b0;
      b_q  <= 1'b0;
    end
  end

  assign lif.a = a_q;
  assign lif.b = b_q;
endmodule

// File: rtl/fmc_adc_lvds_stim_gen.sv
// rtl/fmc_adc_lvds_stim_gen.sv - pattern generator driving per-channel two-lane LVDS-style serial streams
module fmc_adc_lvds_stim_gen
  import fmc_adc_stim_pkg::*;
#(
  parameter int g_NB_CHANNELS  = C_NB_CHANNELS,
  parameter int g_SAMPLE_WIDTH = C_SAMPLE_WIDTH,
  parameter int g_FRAME_BITS   = C_FRAME_BITS
) (
  input  logic                                    clk_i,
  input  logic                                    rst_n_i,
  input  logic                                    enable_i,
  input  logic [1:0]                              mode_i,
  input  logic [g_SAMPLE_WIDTH-1:0]               step_i,
  input  logic [g_SAMPLE_WIDTH-1:0]               limit_i,
  input  logic [g_SAMPLE_WIDTH-1:0]               const_i,
  input  logic [g_SAMPLE_WIDTH-1:0]               ch_offset_i,
  output logic                                    fr_o,
  output logic [g_NB_CHANNELS-1:0]                outa_o,
  output logic [g_NB_CHANNELS-1:0]                outb_o,
  output logic [g_NB_CHANNELS*g_SAMPLE_WIDTH-1:0] sample_o,
  output logic                                    sample_valid_o
);
  localparam int W  = g_SAMPLE_WIDTH;
  localparam int N  = g_NB_CHANNELS;
  localparam int SW = (g_FRAME_BITS > 1) ? $clog2(g_FRAME_BITS) : 1;

  logic [SW-1:0]  slot_q, slot_d;
  logic [W-1:0]   v_q, v_d;
  dir_e           dir_q, dir_d, tri_dir;
  logic           fr_q, fr_d;
  logic           act_q, act_d;
  logic           valid_q, valid_d;
  logic [N*W-1:0] sample_q, sample_d, sample_new;
  logic [W-1:0]   acc;
  logic           slot0, slot_last, load_en, shift_en;

  assign slot0     = (slot_q == '0);
  assign slot_last = (slot_q == SW'(g_FRAME_BITS - 1));
  assign load_en   = slot0 && enable_i;
  // Shifting stops on the last slot so the lanes sit at zero during slot 0
  assign shift_en  = enable_i && act_q && !slot0 && !slot_last;

  // Next-state: slot/frame timing, base value update on enabled slot-0 edges, per-channel samples
  always_comb begin
    slot_d     = slot_last ? '0 : slot_q + SW'(1);
    fr_d       = (slot_d < SW'(g_FRAME_BITS / 2));
    v_d        = v_q;
    dir_d      = dir_q;
    tri_dir    = dir_q;
    sample_new = '0;
    acc        = '0;
    if (load_en) begin
      case (mode_e'(mode_i))
        MODE_CONST: v_d = const_i;
        MODE_RAMP:  v_d = v_q + step_i;
        MODE_TRI: begin
          if ($signed(v_q) > $signed(limit_i) || $signed(v_q) < -$signed(limit_i))
            tri_dir = (dir_q == DIR_UP) ? DIR_DOWN : DIR_UP;
          dir_d = tri_dir;
          v_d   = (tri_dir == DIR_UP) ? v_q + step_i : v_q - step_i;
        end
        MODE_COUNT: v_d = v_q + W'(1);
      endcase
    end
    acc = v_d;
    for (int k = 0; k < N; k++) begin
      sample_new[k*W +: W] = acc;
      acc = acc + ch_offset_i;
    end
    sample_d = load_en ? sample_new : sample_q;
    valid_d  = load_en;
    act_d    = enable_i && (slot0 || act_q);
  end

  // State registers; reset aborts any frame in flight and restarts at slot 0
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      slot_q   <= '0;
      v_q      <= '0;
      dir_q    <= DIR_UP;
      fr_q     <= 1'b0;
      act_q    <= 1'b0;
      valid_q  <= 1'b0;
      sample_q <= '0;
    end else begin
      slot_q   <= slot_d;
      v_q      <= v_d;
      dir_q    <= dir_d;
      fr_q     <= fr_d;
      act_q    <= act_d;
      valid_q  <= valid_d;
      sample_q <= sample_d;
    end
  end

  for (genvar k = 0; k < N; k++) begin : g_lane
    fmc_adc_lane_if #(.g_SAMPLE_WIDTH(W)) lif ();

    assign lif.load  = load_en;
    assign lif.shift = shift_en;
    assign lif.data  = sample_new[k*W +: W];

    fmc_adc_lvds_lane_ser #(.g_SAMPLE_WIDTH(W)) u_ser (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .lif     (lif.slave)
    );

    assign outa_o[k] = lif.a;
    assign outb_o[k] = lif.b;
  end

  assign fr_o           = fr_q;
  assign sample_o       = sample_q;
  assign sample_valid_o = valid_q;
endmodule

// File: tb/tb_fmc_adc_lvds_stim_gen.sv
// tb/tb_fmc_adc_lvds_stim_gen.sv - self-checking bench for the LVDS ADC stimulus generator
module tb_fmc_adc_lvds_stim_gen;
  localparam int N = 4;
  localparam int W = 14;
  localparam int F = 8;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           en;
  logic [1:0]     mode;
  logic [W-1:0]   step, limit, cnst, off;
  logic           fr;
  logic [N-1:0]   outa, outb;
  logic [N*W-1:0] sample;
  logic           valid;

  int checks = 0;
  int failures = 0;
  bit cmp_en = 1'b0;

  fmc_adc_lvds_stim_gen #(.g_NB_CHANNELS(N), .g_SAMPLE_WIDTH(W), .g_FRAME_BITS(F)) dut (
    .clk_i          (clk),
    .rst_n_i        (rst_n),
    .enable_i       (en),
    .mode_i         (mode),
    .step_i         (step),
    .limit_i        (limit),
    .const_i        (cnst),
    .ch_offset_i    (off),
    .fr_o           (fr),
    .outa_o         (outa),
    .outb_o         (outb),
    .sample_o       (sample),
    .sample_valid_o (valid)
  );

  always #5 clk = ~clk;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int wrapw(int x);
    int m;
    m = x & ((1 << W) - 1);
    if (m >= (1 << (W - 1))) m -= (1 << W);
    return m;
  endfunction

  // Reference model: tracks the frame position and base value in plain integers
  int           pos;
  int           mv;
  int           mdir;
  bit           live;
  int           msamp[N];
  logic         exp_fr, exp_valid;
  logic [N-1:0] exp_a, exp_b;

  always @(posedge clk) begin
    int nxt, lim;
    if (!rst_n) begin
      pos = 0; mv = 0; mdir = 1; live = 0;
      exp_fr = 0; exp_valid = 0; exp_a = '0; exp_b = '0;
      for (int k = 0; k < N; k++) msamp[k] = 0;
    end else begin
      nxt = (pos + 1) % F;
      exp_valid = 0;
      if (!en) live = 0;
      else if (pos == 0) begin
        case (mode)
          2'd0: mv = wrapw(int'(cnst));
          2'd1: mv = wrapw(mv + int'(step));
          2'd2: begin
            lim = wrapw(int'(limit));
            if (mv > lim || mv < -lim) mdir = -mdir;
            mv = wrapw(mv + mdir * int'(step));
          end
          default: mv = wrapw(mv + 1);
        endcase
        for (int k = 0; k < N; k++) msamp[k] = wrapw(mv + k * wrapw(int'(off)));
        exp_valid = 1;
        live = 1;
      end
      exp_fr = (nxt < F / 2);
      for (int k = 0; k < N; k++) begin
        if (live && nxt >= 1 && nxt <= W / 2) begin
          exp_a[k] = 1'((msamp[k] >> (W + 1 - 2 * nxt)) & 1);
          exp_b[k] = 1'((msamp[k] >> (W - 2 * nxt)) & 1);
        end else begin
          exp_a[k] = 1'b0;
          exp_b[k] = 1'b0;
        end
      end
      pos = nxt;
    end
  end

  // Cycle-by-cycle comparison against the model
  always @(negedge clk) begin
    logic [N*W-1:0] exp_s;
    if (cmp_en) begin
      for (int k = 0; k < N; k++) exp_s[k*W +: W] = W'(msamp[k]);
      chk("model_fr", 64'(fr), 64'(exp_fr));
      chk("model_outa", 64'(outa), 64'(exp_a));
      chk("model_outb", 64'(outb), 64'(exp_b));
      chk("model_sample", 64'(sample), 64'(exp_s));
      chk("model_valid", 64'(valid), 64'(exp_valid));
    end
  end

  task automatic wait_slot(int s);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (pos != s && n < 2 * F + 2);
    chk("wait_slot", 64'(pos), 64'(s));
  endtask

  initial begin
    logic [6:0]   lit_a, lit_b;
    int           val, vmax, vmin, s0;
    logic [N*W-1:0] lit_s;

    rst_n = 0; en = 0; mode = 0; step = 0; limit = 0; cnst = 0; off = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    cmp_en = 1;
    chk("reset_fr", 64'(fr), 0);
    chk("reset_lanes", 64'({outa, outb}), 0);
    chk("reset_sample", 64'(sample), 0);
    chk("reset_valid", 64'(valid), 0);

    // Constant 0x1ABC: slots 1..7 carry bit pairs (13,12),(11,10)...(1,0)
    en = 1; mode = 2'd0; cnst = 14'h1ABC; rst_n = 1;
    lit_a = 7'b0111110;  // slot1 in MSB
    lit_b = 7'b1000110;
    wait_slot(1);
    chk("const_valid", 64'(valid), 1);
    for (int s = 1; s <= 7; s++) begin
      if (s > 1) @(negedge clk);
      chk("const_outa0", 64'(outa[0]), 64'(lit_a[7 - s]));
      chk("const_outb0", 64'(outb[0]), 64'(lit_b[7 - s]));
    end
    wait_slot(0);
    chk("slot0_lanes", 64'({outa, outb}), 0);

    // Per-channel offset
    cnst = 0; off = 14'd100;
    wait_slot(1);
    lit_s = {14'd300, 14'd200, 14'd100, 14'd0};
    chk("offset_sample", 64'(sample), 64'(lit_s));
    cnst = 14'd50;
    wait_slot(4);
    chk("midframe_hold", 64'(sample), 64'(lit_s));
    wait_slot(1);
    lit_s = {14'd350, 14'd250, 14'd150, 14'd50};
    chk("midframe_next", 64'(sample), 64'(lit_s));

    // Ramp wrap from 0x1FFF
    wait_slot(0);
    cnst = 14'h1FFF; off = 0;
    wait_slot(1);
    chk("ramp_pre", 64'(sample[W-1:0]), 64'h1FFF);
    mode = 2'd1; step = 14'd1;
    wait_slot(1);
    chk("ramp_wrap", 64'(sample[W-1:0]), 64'h2000);
    chk("ramp_wrap_neg", 64'(wrapw(int'(sample[W-1:0]))), 64'(-8192));

    // Triangle step 8 limit 400 from v=0
    mode = 2'd0; cnst = 0;
    wait_slot(1);
    mode = 2'd2; step = 14'd8; limit = 14'd400;
    vmax = -100000; vmin = 100000;
    for (int f = 0; f < 160; f++) begin
      wait_slot(1);
      val = wrapw(int'(sample[W-1:0]));
      if (val > vmax) vmax = val;
      if (val < vmin) vmin = val;
      if (f == 0)  chk("tri_first", 64'(val), 64'(8));
      if (f == 50) chk("tri_peak", 64'(val), 64'(408));
      if (f == 51) chk("tri_turn", 64'(val), 64'(400));
    end
    chk("tri_max", 64'(vmax), 64'(408));
    chk("tri_min", 64'(vmin), 64'(-408));

    // Enable drop at slot 4, re-enable at slot 3
    mode = 2'd3; step = 0;
    wait_slot(1);
    wait_slot(1);
    s0 = int'(sample[W-1:0]);
    wait_slot(4);
    en = 0;
    for (int s = 5; s <= 8; s++) begin
      @(negedge clk);
      chk("dis_lanes", 64'({outa, outb}), 0);
      chk("dis_fr", 64'(fr), 64'((s % F) < F / 2));
    end
    wait_slot(1);
    chk("dis_valid", 64'(valid), 0);
    chk("dis_frozen", 64'(sample[W-1:0]), 64'(s0));
    wait_slot(3);
    en = 1;
    wait_slot(4);
    chk("reen_lanes", 64'({outa, outb}), 0);
    wait_slot(1);
    chk("reen_valid", 64'(valid), 1);
    chk("reen_value", 64'(sample[W-1:0]), 64'((s0 + 1) & 16'h3FFF));

    // Reset at slot 5
    mode = 2'd0; cnst = 14'h1ABC;
    wait_slot(5);
    rst_n = 0;
    @(negedge clk);
    chk("rst_fr", 64'(fr), 0);
    chk("rst_lanes", 64'({outa, outb}), 0);
    chk("rst_sample", 64'(sample), 0);
    chk("rst_valid", 64'(valid), 0);
    rst_n = 1;
    wait_slot(1);
    chk("rel_valid", 64'(valid), 1);
    chk("rel_sample", 64'(sample[W-1:0]), 64'h1ABC);
    wait_slot(0);
    chk("rel_fr", 64'(fr), 1);

    repeat (4) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
